exec_stage_mc: RTL and testbench

Parametrised execute stage with E→M pipeline register. It adds operand forwarding, a branch-type select, valid/flush bubbles, and an iterative multi-cycle MUL/DIVU/REMU unit that stalls upstream through `busy_e`. It sits between the decode/E register and the memory stage, and is the drop-in successor of the single-cycle execute stage.

---
 rtl/exec_stage_mc.sv | 217 +++++++++++++++++++++
 tb/tb_exec_stage_mc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_mc.sv
// Execute stage with E->M pipeline register, operand forwarding and branch resolve.
// Define EXEC_STAGE_MC_MULDIV_EN to build in the iterative MUL/DIVU/REMU unit (codes 9-11).
module exec_stage_mc #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_e,
  input  logic            flush_e,
  input  logic            reg_write_e,
  input  logic            mem_write_e,
  input  logic            result_src_e,
  input  logic            alu_src_e,
  input  logic            branch_e,
  input  logic            branch_ne_e,
  input  logic [3:0]      alu_ctrl_e,
  input  logic [XLEN-1:0] rd1_e,
  input  logic [XLEN-1:0] rd2_e,
  input  logic [XLEN-1:0] imm_ext_e,
  input  logic [XLEN-1:0] pc_e,
  input  logic [XLEN-1:0] pc_plus4_e,
  input  logic [RA_W-1:0] rd_e,
  input  logic [XLEN-1:0] result_w,
  input  logic [1:0]      fwd_a_e,
  input  logic [1:0]      fwd_b_e,
  output logic            busy_e,
  output logic            pc_src_e,
  output logic [XLEN-1:0] pc_target_e,
  output logic            valid_m,
  output logic            reg_write_m,
  output logic            mem_write_m,
  output logic            result_src_m,
  output logic [RA_W-1:0] rd_m,
  output logic [XLEN-1:0] pc_plus4_m,
  output logic [XLEN-1:0] write_data_m,
  output logic [XLEN-1:0] alu_result_m
);

  localparam int unsigned ShW = $clog2(XLEN);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpSlt  = 4'd4;
  localparam logic [3:0] OpXor  = 4'd5;
  localparam logic [3:0] OpSll  = 4'd6;
  localparam logic [3:0] OpSrl  = 4'd7;
  localparam logic [3:0] OpSra  = 4'd8;
  localparam logic [3:0] OpMul  = 4'd9;
  localparam logic [3:0] OpDivu = 4'd10;
  localparam logic [3:0] OpRemu = 4'd11;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] fwd_b;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] alu_result;
  logic [ShW-1:0]  shamt;
  logic            zero;
  logic            load_ok;

  always_comb begin
    case (fwd_a_e)
      2'b01:   src_a = result_w;
      2'b10:   src_a = alu_result_m;
      default: src_a = rd1_e;
    endcase
    case (fwd_b_e)
      2'b01:   fwd_b = result_w;
      2'b10:   fwd_b = alu_result_m;
      default: fwd_b = rd2_e;
    endcase
  end

  assign src_b = alu_src_e ? imm_ext_e : fwd_b;
  assign shamt = src_b[ShW-1:0];

  always_comb begin
    alu_out = '0;
    case (alu_ctrl_e)
      OpAdd:   alu_out = src_a + src_b;
      OpSub:   alu_out = src_a - src_b;
      OpAnd:   alu_out = src_a & src_b;
      OpOr:    alu_out = src_a | src_b;
      OpSlt:   alu_out = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OpXor:   alu_out = src_a ^ src_b;
      OpSll:   alu_out = src_a << shamt;
      OpSrl:   alu_out = src_a >> shamt;
      OpSra:   alu_out = $signed(src_a) >>> shamt;
      default: alu_out = '0;
    endcase
  end

`ifdef EXEC_STAGE_MC_MULDIV_EN
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [ShW-1:0] CntLast = ShW'(XLEN - 1);

  state_e          state_q, state_d;
  logic [ShW-1:0]  cnt_q, cnt_d;
  // acc: product or partial remainder; opa: multiplicand or dividend/quotient; opb: multiplier or divisor
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic            is_mul_q, is_mul_d;
  logic            is_rem_q, is_rem_d;
  logic            muldiv;
  logic [XLEN:0]   rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_diff;
  logic [XLEN-1:0] md_result;

  assign muldiv = (alu_ctrl_e == OpMul) || (alu_ctrl_e == OpDivu) || (alu_ctrl_e == OpRemu);

  // Restoring step; a zero divisor always subtracts, giving all-ones quotient and dividend remainder.
  assign rem_sh   = {acc_q, opa_q[XLEN-1]};
  assign rem_ge   = rem_sh >= {1'b0, opb_q};
  assign rem_diff = rem_sh[XLEN-1:0] - opb_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    is_mul_d = is_mul_q;
    is_rem_d = is_rem_q;
    unique case (state_q)
      StIdle: begin
        if (valid_e && muldiv) begin
          state_d  = StRun;
          cnt_d    = '0;
          acc_d    = '0;
          opa_d    = src_a;
          opb_d    = src_b;
          is_mul_d = (alu_ctrl_e == OpMul);
          is_rem_d = (alu_ctrl_e == OpRemu);
        end
      end
      StRun: begin
        if (is_mul_q) begin
          if (opb_q[0]) acc_d = acc_q + opa_q;
          opa_d = opa_q << 1;
          opb_d = opb_q >> 1;
        end else begin
          acc_d = rem_ge ? rem_diff : rem_sh[XLEN-1:0];
          opa_d = {opa_q[XLEN-2:0], rem_ge};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_e) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      is_mul_q <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      is_mul_q <= is_mul_d;
      is_rem_q <= is_rem_d;
    end
  end

  assign md_result  = (is_mul_q || is_rem_q) ? acc_q : opa_q;
  assign alu_result = (state_q == StDone) ? md_result : alu_out;
  assign busy_e     = ~flush_e & (((state_q == StIdle) & valid_e & muldiv) | (state_q == StRun));
`else
  assign alu_result = alu_out;
  assign busy_e     = 1'b0;
`endif

  assign zero        = (alu_result == '0);
  assign pc_target_e = pc_e + imm_ext_e;
  assign pc_src_e    = valid_e & ~flush_e & branch_e & (zero ^ branch_ne_e);

  // A stalled or flushed cycle loads a bubble into M.
  assign load_ok = valid_e & ~flush_e & ~busy_e;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m      <= 1'b0;
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      result_src_m <= 1'b0;
      rd_m         <= '0;
      pc_plus4_m   <= '0;
      write_data_m <= '0;
      alu_result_m <= '0;
    end else begin
      valid_m      <= load_ok;
      reg_write_m  <= load_ok & reg_write_e;
      mem_write_m  <= load_ok & mem_write_e;
      result_src_m <= load_ok & result_src_e;
      rd_m         <= rd_e;
      pc_plus4_m   <= pc_plus4_e;
      write_data_m <= fwd_b;
      alu_result_m <= alu_result;
    end
  end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Scoreboard bench for exec_stage_mc: stimulus pushes expected M records, a monitor pops them.
module tb_exec_stage_mc;

`ifdef EXEC_STAGE_MC_MULDIV_EN
  localparam bit MdEn = 1'b1;
`else
  localparam bit MdEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_e, flush_e, reg_write_e, mem_write_e, result_src_e, alu_src_e;
  logic        branch_e, branch_ne_e;
  logic [3:0]  alu_ctrl_e;
  logic [31:0] rd1_e, rd2_e, imm_ext_e, pc_e, pc_plus4_e, result_w;
  logic [4:0]  rd_e;
  logic [1:0]  fwd_a_e, fwd_b_e;
  logic        busy_e, pc_src_e;
  logic [31:0] pc_target_e;
  logic        valid_m, reg_write_m, mem_write_m, result_src_m;
  logic [4:0]  rd_m;
  logic [31:0] pc_plus4_m, write_data_m, alu_result_m;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] res;
    logic [31:0] wd;
    logic [31:0] pc4;
    logic [2:0]  ctl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_stage_mc #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .valid_e(valid_e), .flush_e(flush_e),
    .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .result_src_e(result_src_e),
    .alu_src_e(alu_src_e), .branch_e(branch_e), .branch_ne_e(branch_ne_e),
    .alu_ctrl_e(alu_ctrl_e), .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_ext_e(imm_ext_e),
    .pc_e(pc_e), .pc_plus4_e(pc_plus4_e), .rd_e(rd_e), .result_w(result_w),
    .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .busy_e(busy_e), .pc_src_e(pc_src_e),
    .pc_target_e(pc_target_e), .valid_m(valid_m), .reg_write_m(reg_write_m),
    .mem_write_m(mem_write_m), .result_src_m(result_src_m), .rd_m(rd_m),
    .pc_plus4_m(pc_plus4_m), .write_data_m(write_data_m), .alu_result_m(alu_result_m)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid M record must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_m) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL m_unexpected: got valid_m=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        chk("m_alu_result", alu_result_m, e.res);
        chk("m_rd", {27'b0, rd_m}, {27'b0, e.rd});
        chk("m_write_data", write_data_m, e.wd);
        chk("m_pc_plus4", pc_plus4_m, e.pc4);
        chk("m_ctl", {29'b0, reg_write_m, mem_write_m, result_src_m}, {29'b0, e.ctl});
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    valid_e = 0; flush_e = 0; reg_write_e = 0; mem_write_e = 0; result_src_e = 0;
    alu_src_e = 0; branch_e = 0; branch_ne_e = 0; alu_ctrl_e = 0; fwd_a_e = 0; fwd_b_e = 0;
  endtask

  task automatic issue(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input logic asrc, input logic [31:0] imm, input logic [1:0] fa,
                       input logic [1:0] fb, input logic [4:0] rd, input logic [31:0] res,
                       input logic [31:0] wd, input bit push);
    exp_t e;
    @(posedge clk); #1;
    valid_e = 1; flush_e = 0; branch_e = 0; branch_ne_e = 0;
    reg_write_e = 1; mem_write_e = rd[1]; result_src_e = rd[0];
    alu_ctrl_e = ctrl; rd1_e = a; rd2_e = b; alu_src_e = asrc; imm_ext_e = imm;
    fwd_a_e = fa; fwd_b_e = fb; rd_e = rd; pc_plus4_e = 32'h400 + {25'b0, rd, 2'b00};
    e.rd = rd; e.res = res; e.wd = wd; e.pc4 = 32'h400 + {25'b0, rd, 2'b00};
    e.ctl = {1'b1, rd[1], rd[0]};
    if (push) sb.push_back(e);
  endtask

  // Counts busy cycles of a just-issued op; stops in the first non-busy cycle.
  task automatic wait_md(input string name);
    int n = 0;
    bit bub_bad = 0;
    @(negedge clk);
    while (busy_e && n < 100) begin
      n++;
      if (n >= 2 && valid_m) bub_bad = 1;
      @(negedge clk);
    end
    chk({name, "_busy_cycles"}, n, MdEn ? 32'd33 : 32'd0);
    chk({name, "_stall_bubbles"}, {31'b0, bub_bad}, 32'd0);
  endtask

  function automatic logic [31:0] md(input logic [31:0] v);
    return MdEn ? v : 32'd0;
  endfunction

  initial begin
    rst = 1; valid_e = 0; flush_e = 0; reg_write_e = 0; mem_write_e = 0; result_src_e = 0;
    alu_src_e = 0; branch_e = 0; branch_ne_e = 0; alu_ctrl_e = 0; rd1_e = 0; rd2_e = 0;
    imm_ext_e = 0; pc_e = 0; pc_plus4_e = 0; rd_e = 0; result_w = 0; fwd_a_e = 0; fwd_b_e = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_valid_m", {31'b0, valid_m}, 32'd0);
    chk("rst_ctl_m", {29'b0, reg_write_m, mem_write_m, result_src_m}, 32'd0);
    chk("rst_alu_result_m", alu_result_m, 32'd0);
    chk("rst_data_m", write_data_m | pc_plus4_m | {27'b0, rd_m}, 32'd0);
    chk("rst_busy_pcsrc", {30'b0, busy_e, pc_src_e}, 32'd0);

    // Forwarding and single-cycle ALU ops
    issue(4'd0, 32'd4, 32'd6, 0, 0, 2'b00, 2'b00, 5'd1, 32'd10, 32'd6, 1);
    issue(4'd0, 32'd5, 32'd3, 0, 0, 2'b10, 2'b00, 5'd2, 32'd13, 32'd3, 1);
    result_w = 32'd100;
    issue(4'd1, 32'd150, 32'd1, 0, 0, 2'b00, 2'b01, 5'd3, 32'd50, 32'd100, 1);
    issue(4'd3, 32'hF0, 32'h55, 1, 32'h0F, 2'b00, 2'b00, 5'd4, 32'hFF, 32'h55, 1);
    issue(4'd2, 32'hFF00FF00, 32'h0F0F0F0F, 0, 0, 2'b00, 2'b00, 5'd5, 32'h0F000F00, 32'h0F0F0F0F, 1);
    issue(4'd5, 32'hFFFF0000, 32'h0F0F0F0F, 0, 0, 2'b00, 2'b00, 5'd6, 32'hF0F00F0F, 32'h0F0F0F0F, 1);
    issue(4'd4, 32'hFFFFFFFF, 32'd1, 0, 0, 2'b00, 2'b00, 5'd7, 32'd1, 32'd1, 1);
    issue(4'd4, 32'd1, 32'hFFFFFFFF, 0, 0, 2'b00, 2'b00, 5'd8, 32'd0, 32'hFFFFFFFF, 1);
    issue(4'd6, 32'd1, 32'd33, 0, 0, 2'b00, 2'b00, 5'd9, 32'd2, 32'd33, 1);
    issue(4'd7, 32'h80000000, 32'd31, 0, 0, 2'b00, 2'b00, 5'd10, 32'd1, 32'd31, 1);
    issue(4'd8, 32'h80000000, 32'd4, 0, 0, 2'b00, 2'b00, 5'd11, 32'hF8000000, 32'd4, 1);
    issue(4'd12, 32'd5, 32'd6, 0, 0, 2'b00, 2'b00, 5'd12, 32'd0, 32'd6, 1);
    issue(4'd15, 32'd5, 32'd6, 0, 0, 2'b00, 2'b00, 5'd13, 32'd0, 32'd6, 1);

    // Branches: SUB 4-4 gives zero
    pc_e = 32'h1000;
    issue(4'd1, 32'd4, 32'd4, 0, 32'h20, 2'b00, 2'b00, 5'd14, 32'd0, 32'd4, 1);
    branch_e = 1; branch_ne_e = 1;
    @(negedge clk);
    chk("bne_equal_pc_src", {31'b0, pc_src_e}, 32'd0);
    issue(4'd1, 32'd4, 32'd4, 0, 32'h20, 2'b00, 2'b00, 5'd15, 32'd0, 32'd4, 1);
    branch_e = 1; branch_ne_e = 0;
    @(negedge clk);
    chk("beq_equal_pc_src", {31'b0, pc_src_e}, 32'd1);
    chk("beq_pc_target", pc_target_e, 32'h1020);
    issue(4'd1, 32'd4, 32'd5, 0, 32'h20, 2'b00, 2'b00, 5'd16, 32'hFFFFFFFF, 32'd5, 1);
    branch_e = 1; branch_ne_e = 1;
    @(negedge clk);
    chk("bne_diff_pc_src", {31'b0, pc_src_e}, 32'd1);

    // Multi-cycle ops, issued back to back
    issue(4'd9, 32'd7, 32'd6, 0, 0, 2'b00, 2'b00, 5'd17, md(32'd42), 32'd6, 1);
    wait_md("mul");
    issue(4'd10, 32'd100, 32'd7, 0, 0, 2'b00, 2'b00, 5'd18, md(32'd14), 32'd7, 1);
    wait_md("divu");
    issue(4'd11, 32'd100, 32'd7, 0, 0, 2'b00, 2'b00, 5'd19, md(32'd2), 32'd7, 1);
    wait_md("remu");
    issue(4'd10, 32'd9, 32'd0, 0, 0, 2'b00, 2'b00, 5'd20, md(32'hFFFFFFFF), 32'd0, 1);
    wait_md("divu_by0");
    issue(4'd11, 32'd9, 32'd0, 0, 0, 2'b00, 2'b00, 5'd21, md(32'd9), 32'd0, 1);
    wait_md("remu_by0");
    issue(4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 2'b00, 2'b00, 5'd22, md(32'd1), 32'hFFFFFFFF, 1);
    wait_md("mul_wrap");

    // Invalid slot: no branch, bubble in M
    idle();
    branch_e = 1;
    @(negedge clk);
    chk("invalid_pc_src", {30'b0, busy_e, pc_src_e}, 32'd0);
    idle();
    @(negedge clk);
    chk("invalid_valid_m", {28'b0, valid_m, reg_write_m, mem_write_m, result_src_m}, 32'd0);

    // Flush of a single-cycle op
    issue(4'd0, 32'd1, 32'd1, 0, 0, 2'b00, 2'b00, 5'd23, 32'd2, 32'd1, 0);
    flush_e = 1;
    idle();
    @(negedge clk);
    chk("flush_alu_bubble", {29'b0, valid_m, reg_write_m, mem_write_m}, 32'd0);

`ifdef EXEC_STAGE_MC_MULDIV_EN
    // Flush mid-RUN
    issue(4'd9, 32'd7, 32'd6, 0, 0, 2'b00, 2'b00, 5'd24, 32'd42, 32'd6, 0);
    repeat (10) @(posedge clk);
    #1 flush_e = 1;
    @(negedge clk);
    chk("flush_busy", {31'b0, busy_e}, 32'd0);
    idle();
    @(negedge clk);
    chk("flush_md_bubble", {30'b0, valid_m, reg_write_m}, 32'd0);
    issue(4'd10, 32'd50, 32'd5, 0, 0, 2'b00, 2'b00, 5'd25, 32'd10, 32'd5, 1);
    wait_md("after_flush");

    // Reset mid-RUN
    issue(4'd9, 32'd7, 32'd6, 0, 0, 2'b00, 2'b00, 5'd26, 32'd42, 32'd6, 0);
    repeat (5) @(posedge clk);
    #1 rst = 1; valid_e = 0;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_run_busy", {31'b0, busy_e}, 32'd0);
    chk("rst_run_m", {28'b0, valid_m, reg_write_m, mem_write_m, result_src_m}, 32'd0);
    chk("rst_run_alu_m", alu_result_m | write_data_m | pc_plus4_m, 32'd0);
    issue(4'd9, 32'd3, 32'd5, 0, 0, 2'b00, 2'b00, 5'd27, 32'd15, 32'd5, 1);
    wait_md("after_rst");
`endif

    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
